// File: rtl/osd_him_byte_adapter.sv
// rtl/osd_him_byte_adapter.sv - byte<->16-bit word adapter in front of the HIM GLIP ports
// Ingress packs byte pairs into words; egress splits words into byte pairs. Both sides sustain 1 byte/cycle.
module osd_him_byte_adapter #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in_data,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [15:0] word_out_data,
  output logic        word_out_valid,
  input  logic        word_out_ready,
  input  logic [15:0] word_in_data,
  input  logic        word_in_valid,
  output logic        word_in_ready,
  output logic [7:0]  byte_out_data,
  output logic        byte_out_valid,
  input  logic        byte_out_ready,
  input  logic        ingress_flush,
  output logic        ingress_partial
);

  typedef enum logic [1:0] {ING_EMPTY, ING_HALF, ING_FULL} ing_state_t;
  typedef enum logic [1:0] {EG_IDLE, EG_FIRST, EG_SECOND} eg_state_t;

  ing_state_t  r_ing_state, w_ing_next;
  logic [7:0]  r_first, w_first_next;
  logic [15:0] r_word_out, w_word_out_next;

  eg_state_t   r_eg_state, w_eg_next;
  logic [15:0] r_word_in, w_word_in_next;
  logic [7:0]  w_eg_first, w_eg_second;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ing_state <= ING_EMPTY;
      r_first     <= 8'h00;
      r_word_out  <= 16'h0000;
      r_eg_state  <= EG_IDLE;
      r_word_in   <= 16'h0000;
    end else begin
      r_ing_state <= w_ing_next;
      r_first     <= w_first_next;
      r_word_out  <= w_word_out_next;
      r_eg_state  <= w_eg_next;
      r_word_in   <= w_word_in_next;
    end
  end

  // A flush drops both the held half and any byte accepted in the same cycle, except in EMPTY.
  always_comb begin
    w_ing_next      = r_ing_state;
    w_first_next    = r_first;
    w_word_out_next = r_word_out;
    byte_in_ready   = 1'b1;
    word_out_valid  = 1'b0;
    ingress_partial = 1'b0;
    case (r_ing_state)
      ING_EMPTY: begin
        if (byte_in_valid) begin
          w_first_next = byte_in_data;
          w_ing_next   = ING_HALF;
        end
      end
      ING_HALF: begin
        ingress_partial = 1'b1;
        if (ingress_flush) begin
          w_ing_next = ING_EMPTY;
        end else if (byte_in_valid) begin
          w_word_out_next = MSB_FIRST ? {r_first, byte_in_data} : {byte_in_data, r_first};
          w_ing_next      = ING_FULL;
        end
      end
      ING_FULL: begin
        word_out_valid = 1'b1;
        byte_in_ready  = word_out_ready;
        if (word_out_ready) begin
          if (byte_in_valid && !ingress_flush) begin
            w_first_next = byte_in_data;
            w_ing_next   = ING_HALF;
          end else begin
            w_ing_next = ING_EMPTY;
          end
        end
      end
      default: w_ing_next = ING_EMPTY;
    endcase
  end

  assign word_out_data = r_word_out;

  assign w_eg_first  = MSB_FIRST ? r_word_in[15:8] : r_word_in[7:0];
  assign w_eg_second = MSB_FIRST ? r_word_in[7:0]  : r_word_in[15:8];

  always_comb begin
    w_eg_next      = r_eg_state;
    w_word_in_next = r_word_in;
    word_in_ready  = 1'b0;
    byte_out_valid = 1'b0;
    byte_out_data  = 8'h00;
    case (r_eg_state)
      EG_IDLE: begin
        word_in_ready = 1'b1;
        if (word_in_valid) begin
          w_word_in_next = word_in_data;
          w_eg_next      = EG_FIRST;
        end
      end
      EG_FIRST: begin
        byte_out_valid = 1'b1;
        byte_out_data  = w_eg_first;
        if (byte_out_ready) w_eg_next = EG_SECOND;
      end
      EG_SECOND: begin
        byte_out_valid = 1'b1;
        byte_out_data  = w_eg_second;
        word_in_ready  = byte_out_ready;
        if (byte_out_ready) begin
          if (word_in_valid) begin
            w_word_in_next = word_in_data;
            w_eg_next      = EG_FIRST;
          end else begin
            w_eg_next = EG_IDLE;
          end
        end
      end
      default: w_eg_next = EG_IDLE;
    endcase
  end

endmodule

// File: tb/tb_osd_him_byte_adapter.sv
// tb/tb_osd_him_byte_adapter.sv - scoreboard bench for osd_him_byte_adapter, both byte orders
// One DUT per MSB_FIRST setting, driven by the same stimulus; a negedge monitor checks against a queue model.
module tb_osd_him_byte_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in_data;
  logic        byte_in_valid;
  logic        word_out_ready;
  logic [15:0] word_in_data;
  logic        word_in_valid;
  logic        byte_out_ready;
  logic        ingress_flush;

  logic        byte_in_ready_m, word_out_valid_m, word_in_ready_m, byte_out_valid_m, ingress_partial_m;
  logic [15:0] word_out_data_m;
  logic [7:0]  byte_out_data_m;
  logic        byte_in_ready_l, word_out_valid_l, word_in_ready_l, byte_out_valid_l, ingress_partial_l;
  logic [15:0] word_out_data_l;
  logic [7:0]  byte_out_data_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  osd_him_byte_adapter #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .byte_in_data(byte_in_data), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready_m),
    .word_out_data(word_out_data_m), .word_out_valid(word_out_valid_m), .word_out_ready(word_out_ready),
    .word_in_data(word_in_data), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready_m),
    .byte_out_data(byte_out_data_m), .byte_out_valid(byte_out_valid_m), .byte_out_ready(byte_out_ready),
    .ingress_flush(ingress_flush), .ingress_partial(ingress_partial_m)
  );

  osd_him_byte_adapter #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .byte_in_data(byte_in_data), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready_l),
    .word_out_data(word_out_data_l), .word_out_valid(word_out_valid_l), .word_out_ready(word_out_ready),
    .word_in_data(word_in_data), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready_l),
    .byte_out_data(byte_out_data_l), .byte_out_valid(byte_out_valid_l), .byte_out_ready(byte_out_ready),
    .ingress_flush(ingress_flush), .ingress_partial(ingress_partial_l)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pending half byte, words owed on the ingress side (as {first,second} byte pairs),
  // and bytes owed on the egress side in transport order for each DUT.
  bit          have_half = 1'b0;
  logic [7:0]  half_b;
  logic [15:0] exp_w[$];
  logic [7:0]  eb_m[$];
  logic [7:0]  eb_l[$];
  bit          in_acc = 1'b0;
  bit          win_acc = 1'b0;
  bit          saw03 = 1'b0;

  always @(negedge clk) begin
    bit          pend, acc, ne, rdy;
    logic [15:0] p;
    in_acc  = 1'b0;
    win_acc = 1'b0;
    if (rst) begin
      have_half = 1'b0;
      exp_w.delete();
      eb_m.delete();
      eb_l.delete();
    end else begin
      pend = (exp_w.size() != 0);
      chk("partial_m", ingress_partial_m, have_half);
      chk("partial_l", ingress_partial_l, have_half);
      chk("wout_valid_m", word_out_valid_m, pend);
      chk("wout_valid_l", word_out_valid_l, pend);
      chk("bin_ready_m", byte_in_ready_m, !pend || word_out_ready);
      chk("bin_ready_l", byte_in_ready_l, !pend || word_out_ready);
      if (pend) begin
        p = exp_w[0];
        chk("wout_data_m", word_out_data_m, p);
        chk("wout_data_l", word_out_data_l, {p[7:0], p[15:8]});
        if (word_out_ready) void'(exp_w.pop_front());
      end
      acc = byte_in_valid && (!pend || word_out_ready);
      in_acc = acc;
      if (ingress_flush) begin
        if (have_half) have_half = 1'b0;
        else if (!pend && acc) begin
          have_half = 1'b1;
          half_b = byte_in_data;
        end
      end else if (acc) begin
        if (have_half) begin
          exp_w.push_back({half_b, byte_in_data});
          have_half = 1'b0;
        end else begin
          have_half = 1'b1;
          half_b = byte_in_data;
        end
      end

      ne  = (eb_m.size() != 0);
      rdy = (eb_m.size() == 0) || (eb_m.size() == 1 && byte_out_ready);
      chk("bout_valid_m", byte_out_valid_m, ne);
      chk("bout_valid_l", byte_out_valid_l, ne);
      chk("win_ready_m", word_in_ready_m, rdy);
      chk("win_ready_l", word_in_ready_l, rdy);
      if (ne) begin
        chk("bout_data_m", byte_out_data_m, eb_m[0]);
        chk("bout_data_l", byte_out_data_l, eb_l[0]);
        if (byte_out_ready) begin
          if (eb_m[0] == 8'h03) saw03 = 1'b1;
          void'(eb_m.pop_front());
          void'(eb_l.pop_front());
        end
      end
      if (word_in_valid && rdy) begin
        win_acc = 1'b1;
        eb_m.push_back(word_in_data[15:8]);
        eb_m.push_back(word_in_data[7:0]);
        eb_l.push_back(word_in_data[7:0]);
        eb_l.push_back(word_in_data[15:8]);
      end
    end
  end

  logic [7:0]  src_b[$];
  logic [15:0] src_w[$];
  int unsigned in_gap = 0, win_gap = 0, wrdy_pct = 100, brdy_pct = 100, flush_pct = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (byte_in_valid && in_acc) byte_in_valid = 1'b0;
    if (!byte_in_valid && src_b.size() > 0 && $urandom_range(99) >= in_gap) begin
      byte_in_data  = src_b.pop_front();
      byte_in_valid = 1'b1;
    end
    if (word_in_valid && win_acc) word_in_valid = 1'b0;
    if (!word_in_valid && src_w.size() > 0 && $urandom_range(99) >= win_gap) begin
      word_in_data  = src_w.pop_front();
      word_in_valid = 1'b1;
    end
    word_out_ready = ($urandom_range(99) < wrdy_pct);
    byte_out_ready = ($urandom_range(99) < brdy_pct);
    ingress_flush  = ($urandom_range(99) < flush_pct);
  endtask

  task automatic drain();
    int n = 0;
    wrdy_pct = 100; brdy_pct = 100; flush_pct = 0; in_gap = 0; win_gap = 0;
    while ((src_b.size() != 0 || src_w.size() != 0 || byte_in_valid || word_in_valid ||
            exp_w.size() != 0 || eb_m.size() != 0) && n < 300) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout at %0t: got %0d cycles expected fewer than 300", $time, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    byte_in_data = 8'h00; byte_in_valid = 1'b0; word_out_ready = 1'b0;
    word_in_data = 16'h0000; word_in_valid = 1'b0; byte_out_ready = 1'b0; ingress_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_bin_ready", byte_in_ready_m, 1);
    chk("rst_win_ready", word_in_ready_m, 1);
    chk("rst_wout_valid", word_out_valid_m, 0);
    chk("rst_bout_valid", byte_out_valid_l, 0);
    chk("rst_partial", ingress_partial_m, 0);
    chk("rst_wout_data", word_out_data_m, 0);
    chk("rst_bout_data", byte_out_data_m, 0);

    src_b = '{8'h12, 8'h34};
    src_w = '{16'hABCD};
    drain();

    for (int i = 1; i <= 8; i++) src_b.push_back(8'(i));
    drain();

    wrdy_pct = 0;
    src_b = '{8'hBE, 8'hEF};
    repeat (3) step();
    src_b.push_back(8'h55);
    repeat (5) step();
    chk("stall_bin_ready", byte_in_ready_m, 0);
    chk("stall_wdata", word_out_data_m, 16'hBEEF);
    src_b.push_back(8'h66);
    drain();

    src_b = '{8'h77};
    step();
    step();
    ingress_flush = 1'b1;
    step();
    src_b = '{8'h11, 8'h22};
    drain();

    src_w = '{16'h0102, 16'h0304};
    saw03 = 1'b0;
    for (int i = 0; i < 20 && !saw03; i++) step();
    rst = 1'b1;
    src_w.delete();
    word_in_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_bout_valid", byte_out_valid_m, 0);
    chk("rst_mid_wout_valid", word_out_valid_m, 0);
    chk("rst_mid_partial", ingress_partial_m, 0);

    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        in_gap    = $urandom_range(60);
        win_gap   = $urandom_range(60);
        wrdy_pct  = 30 + $urandom_range(70);
        brdy_pct  = 30 + $urandom_range(70);
        flush_pct = $urandom_range(8);
      end
      if (src_b.size() < 4) src_b.push_back(8'($urandom));
      if (src_w.size() < 4) src_w.push_back(16'($urandom));
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
